// File: rtl/id_stage_controller_pkg.sv
// Shared RV32IM encodings used by the decode-stage controller: major opcodes,
// funct fields and the immediate-type codes consumed by the sign extender.
package id_stage_controller_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] FUNCT3_SLLI   = 3'b001;
    localparam logic [2:0] FUNCT3_SRXI   = 3'b101;

    // Immediate-type codes; the sign extender sees {zero_extend, code}.
    localparam logic [2:0] IMM_TYPE1 = 3'b001;  // U
    localparam logic [2:0] IMM_TYPE2 = 3'b010;  // J
    localparam logic [2:0] IMM_TYPE3 = 3'b011;  // I
    localparam logic [2:0] IMM_TYPE4 = 3'b100;  // B
    localparam logic [2:0] IMM_TYPE5 = 3'b101;  // S
    localparam logic [2:0] IMM_TYPE6 = 3'b110;  // shamt

    // Packs the zero-extend flag above a 3-bit immediate-type code.
    function automatic logic [3:0] make_imm_sel(input logic zext, input logic [2:0] code);
        return {zext, code};
    endfunction

endpackage

// File: rtl/id_stage_controller_imm_sel_decoder.sv
// Combinational instruction-format decoder: selects the immediate type for the
// sign extender and reports which source registers the instruction reads.
module imm_sel_decoder
    import id_stage_controller_pkg::*;
(
    input  logic [31:0] inst,
    output logic [3:0]  imm_sel,
    output logic        rs1_used,
    output logic        rs2_used
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_inst_bits;

    assign opcode           = inst[6:0];
    assign funct3           = inst[14:12];
    assign unused_inst_bits = ^{inst[31:15], inst[11:7]};

    // Map the major opcode to an immediate format and source-register usage;
    // no RV32IM format needs zero extension, so the top bit is always clear.
    always_comb begin
        imm_sel  = 4'b0000;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: imm_sel = make_imm_sel(1'b0, IMM_TYPE1);
            OPC_JAL:            imm_sel = make_imm_sel(1'b0, IMM_TYPE2);
            OPC_JALR, OPC_LOAD: begin
                imm_sel  = make_imm_sel(1'b0, IMM_TYPE3);
                rs1_used = 1'b1;
            end
            OPC_OP_IMM: begin
                rs1_used = 1'b1;
                if (funct3 == FUNCT3_SLLI || funct3 == FUNCT3_SRXI)
                    imm_sel = make_imm_sel(1'b0, IMM_TYPE6);
                else
                    imm_sel = make_imm_sel(1'b0, IMM_TYPE3);
            end
            OPC_BRANCH: begin
                imm_sel  = make_imm_sel(1'b0, IMM_TYPE4);
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_STORE: begin
                imm_sel  = make_imm_sel(1'b0, IMM_TYPE5);
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OPC_OP: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_stage_controller.sv
// Decode-stage sequencing controller: immediate-type decode, load-use hazard
// interlock, multi-cycle divide occupancy and taken-branch flush.
module id_stage_controller
    import id_stage_controller_pkg::*;
#(
    parameter int DIV_CYCLES = 33
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        if_id_valid,
    input  logic [31:0] inst,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        branch_taken,
    output logic [3:0]  imm_sel,
    output logic        stall_if,
    output logic        bubble_ex,
    output logic        flush_id,
    output logic        div_busy,
    output logic [31:0] stall_cycles
);

    typedef enum logic {
        IDLE,
        DIV_WAIT
    } state_t;

    // The divide spends one cycle issuing in IDLE, the rest counting down here.
    localparam logic [5:0] DIV_WAIT_LOAD = 6'(DIV_CYCLES - 2);

    state_t     state;
    logic [5:0] cnt;
    logic       rs1_used;
    logic       rs2_used;
    logic       load_use;
    logic       div_issue;
    logic       start_div;
    logic [4:0] rs1;
    logic [4:0] rs2;

    imm_sel_decoder u_imm_sel_decoder (
        .inst     (inst),
        .imm_sel  (imm_sel),
        .rs1_used (rs1_used),
        .rs2_used (rs2_used)
    );

    assign rs1 = inst[19:15];
    assign rs2 = inst[24:20];

    assign load_use = if_id_valid && ex_mem_read && (ex_rd != 5'd0) &&
                      ((rs1_used && (ex_rd == rs1)) || (rs2_used && (ex_rd == rs2)));

    assign div_issue = if_id_valid && (inst[6:0] == OPC_OP) &&
                       (inst[31:25] == FUNCT7_MULDIV) && inst[14];

    // Pipeline controls from the current state and inputs; a taken branch
    // outranks a hazard, which outranks a divide issue, and reset silences all.
    always_comb begin
        stall_if  = 1'b0;
        bubble_ex = 1'b0;
        flush_id  = 1'b0;
        div_busy  = 1'b0;
        start_div = 1'b0;
        if (!RESET) begin
            if (state == DIV_WAIT) begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
                div_busy  = 1'b1;
            end else if (branch_taken) begin
                flush_id  = 1'b1;
                bubble_ex = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                bubble_ex = 1'b1;
            end else if (div_issue) begin
                start_div = 1'b1;
            end
        end
    end

    // State and divide countdown; the divide leaves DIV_WAIT once cnt hits zero.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_div) begin
                        state <= DIV_WAIT;
                        cnt   <= DIV_WAIT_LOAD;
                    end
                end
                DIV_WAIT: begin
                    if (cnt == 6'd0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 6'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Performance counter of stalled fetch cycles, pinned at all-ones.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            stall_cycles <= 32'd0;
        else if (stall_if && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
    end

endmodule

// File: tb/tb_id_stage_controller.sv
// Self-checking bench for id_stage_controller: a table of single-cycle vectors,
// hand-written divide/reset/saturation sequences and a randomized run compared
// against a cycle-count reference model.
module tb_id_stage_controller;

    localparam int DIV_CYCLES = 4;

    localparam logic [31:0] I_LUI   = 32'h000012B7;
    localparam logic [31:0] I_LUI5  = 32'h0002A2B7;
    localparam logic [31:0] I_JAL   = 32'h0000006F;
    localparam logic [31:0] I_SLLI  = 32'h00529293;
    localparam logic [31:0] I_SRAI  = 32'h4052D293;
    localparam logic [31:0] I_SW    = 32'h00112023;
    localparam logic [31:0] I_BEQ   = 32'h00000063;
    localparam logic [31:0] I_JALR  = 32'h000080E7;
    localparam logic [31:0] I_ADD   = 32'h00528333;
    localparam logic [31:0] I_ADDI  = 32'h00A28293;
    localparam logic [31:0] I_DIV   = 32'h02C5C533;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        if_id_valid;
    logic [31:0] inst;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        branch_taken;
    logic [3:0]  imm_sel;
    logic        stall_if;
    logic        bubble_ex;
    logic        flush_id;
    logic        div_busy;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // Reference model state: remaining divide wait cycles and total stalls.
    int     waitLeft;
    longint stallTotal;
    logic   mStall, mBubble, mFlush, mBusy, mDiv;
    logic [3:0] mImm;

    typedef struct {
        logic        valid;
        logic [31:0] inst;
        logic        mr;
        logic [4:0]  rd;
        logic        br;
        logic [3:0]  imm;
        logic        stall;
        logic        bubble;
        logic        flush;
    } vec_t;

    vec_t vecs[18];

    id_stage_controller #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .if_id_valid  (if_id_valid),
        .inst         (inst),
        .ex_mem_read  (ex_mem_read),
        .ex_rd        (ex_rd),
        .branch_taken (branch_taken),
        .imm_sel      (imm_sel),
        .stall_if     (stall_if),
        .bubble_ex    (bubble_ex),
        .flush_id     (flush_id),
        .div_busy     (div_busy),
        .stall_cycles (stall_cycles)
    );

    always #5 CLK = ~CLK;

    function automatic logic [3:0] refImm(input logic [31:0] w);
        case (w[6:0])
            7'h37, 7'h17: return 4'd1;
            7'h6F:        return 4'd2;
            7'h67, 7'h03: return 4'd3;
            7'h13:        return (w[14:12] == 3'd1 || w[14:12] == 3'd5) ? 4'd6 : 4'd3;
            7'h63:        return 4'd4;
            7'h23:        return 4'd5;
            default:      return 4'd0;
        endcase
    endfunction

    task automatic modelEval();
        logic [6:0] opc;
        logic use1, use2, hazard, isDiv;
        opc    = inst[6:0];
        use1   = (opc == 7'h67) || (opc == 7'h03) || (opc == 7'h13) ||
                 (opc == 7'h33) || (opc == 7'h63) || (opc == 7'h23);
        use2   = (opc == 7'h33) || (opc == 7'h63) || (opc == 7'h23);
        hazard = if_id_valid && ex_mem_read && (ex_rd != 0) &&
                 ((use1 && ex_rd == inst[19:15]) || (use2 && ex_rd == inst[24:20]));
        isDiv  = if_id_valid && (opc == 7'h33) && (inst[31:25] == 7'd1) && inst[14];
        mImm    = refImm(inst);
        mStall  = 1'b0;
        mBubble = 1'b0;
        mFlush  = 1'b0;
        mBusy   = 1'b0;
        mDiv    = 1'b0;
        if (RESET) begin
        end else if (waitLeft > 0) begin
            mStall = 1'b1; mBubble = 1'b1; mBusy = 1'b1;
        end else if (branch_taken) begin
            mFlush = 1'b1; mBubble = 1'b1;
        end else if (hazard) begin
            mStall = 1'b1; mBubble = 1'b1;
        end else if (isDiv) begin
            mDiv = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic valid, input logic [31:0] w,
                                 input logic mr, input logic [4:0] rd, input logic br);
        RESET        = rst;
        if_id_valid  = valid;
        inst         = w;
        ex_mem_read  = mr;
        ex_rd        = rd;
        branch_taken = br;
        if (rst) begin
            waitLeft   = 0;
            stallTotal = 0;
        end
        #1;
        modelEval();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".imm_sel"},      32'(imm_sel),   32'(mImm));
        checkOutput({tag, ".stall_if"},     32'(stall_if),  32'(mStall));
        checkOutput({tag, ".bubble_ex"},    32'(bubble_ex), 32'(mBubble));
        checkOutput({tag, ".flush_id"},     32'(flush_id),  32'(mFlush));
        checkOutput({tag, ".div_busy"},     32'(div_busy),  32'(mBusy));
        checkOutput({tag, ".stall_cycles"}, stall_cycles,   32'(stallTotal));
    endtask

    // Advance one clock, updating the model with the outputs it predicted.
    task automatic modelClock();
        @(posedge CLK);
        if (!RESET) begin
            if (mStall && stallTotal < 64'hFFFF_FFFF)
                stallTotal++;
            if (waitLeft > 0)
                waitLeft--;
            else if (mDiv)
                waitLeft = DIV_CYCLES - 1;
        end
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] templ [9];
        logic [31:0] w;
        int k;

        waitLeft   = 0;
        stallTotal = 0;
        RESET = 1'b1; if_id_valid = 1'b0; inst = '0;
        ex_mem_read = 1'b0; ex_rd = '0; branch_taken = 1'b0;

        vecs[0]  = '{1'b1, I_LUI,  1'b0, 5'd0,  1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, I_JAL,  1'b0, 5'd0,  1'b0, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, I_SLLI, 1'b0, 5'd0,  1'b0, 4'd6, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, I_SW,   1'b0, 5'd0,  1'b0, 4'd5, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, I_BEQ,  1'b0, 5'd0,  1'b0, 4'd4, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, I_JALR, 1'b0, 5'd0,  1'b0, 4'd3, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, I_SRAI, 1'b0, 5'd0,  1'b0, 4'd6, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, I_ADD,  1'b1, 5'd5,  1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, I_ADD,  1'b1, 5'd0,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, I_ADD,  1'b1, 5'd5,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, I_ADD,  1'b0, 5'd5,  1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, I_SW,   1'b1, 5'd1,  1'b0, 4'd5, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, I_LUI5, 1'b1, 5'd5,  1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, I_ADDI, 1'b1, 5'd5,  1'b0, 4'd3, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, I_ADD,  1'b1, 5'd5,  1'b1, 4'd0, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b1, I_DIV,  1'b1, 5'd11, 1'b1, 4'd0, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, I_DIV,  1'b1, 5'd11, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b1, I_ADDI, 1'b0, 5'd0,  1'b0, 4'd3, 1'b0, 1'b0, 1'b0};

        // Reset state: controls silent even with a branch, imm_sel still tracks.
        @(negedge CLK);
        applyStimulus(1'b1, 1'b1, I_LUI, 1'b1, 5'd1, 1'b1);
        checkAll("reset");
        checkOutput("reset.imm_tracks", 32'(imm_sel), 32'd1);
        checkOutput("reset.flush", 32'(flush_id), 32'd0);
        modelClock();

        // Table vectors, all starting in IDLE; the last one proves the blocked
        // divide never issued.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, vecs[i].valid, vecs[i].inst, vecs[i].mr, vecs[i].rd, vecs[i].br);
            checkOutput($sformatf("vec%0d.imm_sel", i),   32'(imm_sel),   32'(vecs[i].imm));
            checkOutput($sformatf("vec%0d.stall_if", i),  32'(stall_if),  32'(vecs[i].stall));
            checkOutput($sformatf("vec%0d.bubble_ex", i), 32'(bubble_ex), 32'(vecs[i].bubble));
            checkOutput($sformatf("vec%0d.flush_id", i),  32'(flush_id),  32'(vecs[i].flush));
            checkOutput($sformatf("vec%0d.div_busy", i),  32'(div_busy),  32'd0);
            checkOutput($sformatf("vec%0d.stall_cycles", i), stall_cycles, 32'(stallTotal));
            modelClock();
        end

        // Divide occupancy from a clean counter, with back-to-back issue.
        applyStimulus(1'b1, 1'b0, I_ADDI, 1'b0, 5'd0, 1'b0);
        modelClock();
        applyStimulus(1'b0, 1'b1, I_DIV, 1'b0, 5'd0, 1'b0);
        checkOutput("div.issue_stall", 32'(stall_if), 32'd0);
        checkOutput("div.issue_bubble", 32'(bubble_ex), 32'd0);
        checkOutput("div.issue_busy", 32'(div_busy), 32'd0);
        modelClock();
        for (int c = 0; c < DIV_CYCLES - 1; c++) begin
            applyStimulus(1'b0, 1'b1, I_ADD, 1'b1, 5'd5, (c == 1));
            checkOutput($sformatf("div.wait%0d_stall", c), 32'(stall_if), 32'd1);
            checkOutput($sformatf("div.wait%0d_busy", c), 32'(div_busy), 32'd1);
            checkOutput($sformatf("div.wait%0d_flush", c), 32'(flush_id), 32'd0);
            checkAll($sformatf("div.wait%0d", c));
            modelClock();
        end
        applyStimulus(1'b0, 1'b1, I_DIV, 1'b0, 5'd0, 1'b0);
        checkOutput("div.b2b_stall", 32'(stall_if), 32'd0);
        checkOutput("div.b2b_busy", 32'(div_busy), 32'd0);
        checkOutput("div.stall_cycles3", stall_cycles, 32'd3);
        modelClock();
        for (int c = 0; c < DIV_CYCLES - 1; c++) begin
            applyStimulus(1'b0, 1'b1, I_ADDI, 1'b0, 5'd0, 1'b0);
            checkAll($sformatf("div2.wait%0d", c));
            modelClock();
        end
        applyStimulus(1'b0, 1'b1, I_ADDI, 1'b0, 5'd0, 1'b0);
        checkOutput("div2.idle_busy", 32'(div_busy), 32'd0);
        checkOutput("div2.stall_cycles6", stall_cycles, 32'd6);
        modelClock();

        // Reset asserted in the second wait cycle.
        applyStimulus(1'b0, 1'b1, I_DIV, 1'b0, 5'd0, 1'b0);
        modelClock();
        applyStimulus(1'b0, 1'b1, I_ADDI, 1'b0, 5'd0, 1'b0);
        checkOutput("rstdiv.wait1_busy", 32'(div_busy), 32'd1);
        modelClock();
        applyStimulus(1'b1, 1'b1, I_LUI, 1'b0, 5'd0, 1'b1);
        checkOutput("rstdiv.stall", 32'(stall_if), 32'd0);
        checkOutput("rstdiv.bubble", 32'(bubble_ex), 32'd0);
        checkOutput("rstdiv.flush", 32'(flush_id), 32'd0);
        checkOutput("rstdiv.busy", 32'(div_busy), 32'd0);
        checkOutput("rstdiv.imm_sel", 32'(imm_sel), 32'd1);
        checkOutput("rstdiv.stall_cycles", stall_cycles, 32'd0);
        modelClock();
        applyStimulus(1'b0, 1'b1, I_ADDI, 1'b0, 5'd0, 1'b0);
        checkOutput("rstdiv.release_busy", 32'(div_busy), 32'd0);
        checkOutput("rstdiv.release_stall", 32'(stall_if), 32'd0);
        modelClock();

        // Randomized traffic against the reference model.
        templ[0] = I_LUI;  templ[1] = I_JAL;  templ[2] = I_SLLI;
        templ[3] = I_SW;   templ[4] = I_BEQ;  templ[5] = I_JALR;
        templ[6] = I_ADD;  templ[7] = I_ADDI; templ[8] = I_DIV;
        for (int n = 0; n < 400; n++) begin
            k = int'($urandom_range(0, 9));
            w = (k == 9) ? I_DIV : templ[k];
            w[19:15] = 5'($urandom_range(0, 7));
            w[24:20] = 5'($urandom_range(0, 7));
            if (k == 9)
                w[14:12] = 3'($urandom_range(0, 7));
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), w,
                          1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                          ($urandom_range(0, 7) == 0));
            checkAll($sformatf("rand%0d", n));
            modelClock();
        end

        // Saturation of the stall counter near all-ones.
        applyStimulus(1'b1, 1'b0, I_ADDI, 1'b0, 5'd0, 1'b0);
        modelClock();
        applyStimulus(1'b0, 1'b1, I_ADD, 1'b1, 5'd5, 1'b0);
        force dut.stall_cycles = 32'hFFFF_FFFE;
        @(posedge CLK);
        @(negedge CLK);
        release dut.stall_cycles;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("sat.stall_if", 32'(stall_if), 32'd1);
        checkOutput("sat.stall_cycles", stall_cycles, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage_controller.md
# id_stage_controller

Sequencing controller for the decode stage of the RV32IM pipeline. It decodes the IF/ID instruction into the 4-bit `imm_sel` that configures the immediate sign extender. It detects load-use hazards against the ID/EX instruction and interlocks the pipeline for the multi-cycle DIV/DIVU/REM/REMU unit. It also applies taken-branch flushes, driving the stall, bubble and flush controls for the IF/ID and ID/EX registers.

## Interface
- `DIV_CYCLES`, default 33: EX-stage occupancy of one divide/remainder instruction, in cycles. Legal range is 2 to 64.
- `CLK` input, 1: the single clock.
- `RESET` input, 1: asynchronous, active-high reset.
- `if_id_valid` input, 1: IF/ID holds a valid instruction.
- `inst` input, 32: IF/ID instruction word.
- `ex_mem_read` input, 1: the ID/EX instruction is a load.
- `ex_rd` input, 5: destination register of the ID/EX instruction.
- `branch_taken` input, 1: EX resolved a taken branch or jump this cycle.
- `imm_sel` output, 4: immediate-type select for the sign extender.
- `stall_if` output, 1: hold the PC and IF/ID.
- `bubble_ex` output, 1: load a NOP into ID/EX.
- `flush_id` output, 1: invalidate IF/ID.
- `div_busy` output, 1: a divide is occupying EX.
- `stall_cycles` output, 32: saturating count of cycles with `stall_if`=1.

## Operation
- **imm_sel decode.** This path is purely combinational from `inst[6:0]`. Bit 3 is 0 for every RV32IM opcode.
  - LUI/AUIPC → 0001 (U)
  - JAL → 0010 (J)
  - JALR/LOAD/OP-IMM → 0011 (I)
  - SLLI/SRLI/SRAI (OP-IMM with funct3 = 001 or 101) → 0110 (shamt)
  - BRANCH → 0100 (B)
  - STORE → 0101 (S)
  - anything else → 0000
- **Source use.**
  - rs1 (`inst[19:15]`) is used by JALR, LOAD, OP-IMM, OP, BRANCH and STORE.
  - rs2 (`inst[24:20]`) is used by OP, BRANCH and STORE.
- **Load-use hazard.** Asserted when `if_id_valid` & `ex_mem_read` & `ex_rd`≠0 & `ex_rd` equals a used source register.
- **Divide issue.** Asserted when `if_id_valid` & opcode = OP & funct7 = 0000001 & `inst[14]`=1.
- **FSM states.** The state machine has two states, IDLE and DIV_WAIT. It also holds a down-counter `cnt` of 6 bits.
- **IDLE, in priority order:**
  1. `branch_taken` → `flush_id`=1, `bubble_ex`=1, `stall_if`=0. Any hazard or divide in ID is discarded and the state stays IDLE.
  2. Load-use hazard → `stall_if`=1, `bubble_ex`=1, state stays IDLE. The hazard clears automatically next cycle because ID/EX then holds the bubble.
  3. Divide issue → the divide passes to ID/EX (`stall_if`=0, `bubble_ex`=0). Next state is DIV_WAIT with `cnt` ← `DIV_CYCLES`−2.
  4. Otherwise all controls are 0.
- **DIV_WAIT:**
  - `stall_if`=1, `bubble_ex`=1, `div_busy`=1, `flush_id`=0.
  - When `cnt`=0, the next state is IDLE; otherwise `cnt` decrements.
  - `branch_taken` and the hazard/divide inputs are ignored in this state. The divide is the oldest instruction in flight.
- **stall_cycles.** Increments every cycle in which `stall_if`=1 and saturates at 0xFFFF_FFFF.

## Timing
- `stall_if`, `bubble_ex`, `flush_id` and `div_busy` are Mealy outputs from the registered state and the current inputs, valid within the same cycle.
- **Reset (asynchronous, active-high):**
  - State → IDLE, `cnt` → 0, `stall_cycles` → 0.
  - While `RESET`=1, `stall_if`, `bubble_ex`, `flush_id` and `div_busy` are forced to 0. `imm_sel` still tracks `inst`.
- **Reset mid-DIV_WAIT:** the controller is in IDLE on the first cycle after `RESET` deasserts.
- **Load-use penalty:** exactly 1 stall cycle.
- **Divide occupancy:**
  - 1 issue cycle plus `DIV_CYCLES`−1 DIV_WAIT cycles, so EX is occupied for `DIV_CYCLES` cycles in total.
  - The younger instruction is stalled for `DIV_CYCLES`−1 cycles.
  - A back-to-back divide can issue in the first IDLE cycle after DIV_WAIT.
- **Simultaneous events:** `branch_taken` together with a load-use hazard or a divide in ID produces a flush only, with no stall and no state change.

## Structure
- Opcode, funct constants and `IMM_TYPE1`–`IMM_TYPE6` (3-bit codes 001–110) live in the shared encodings include. `imm_sel[3]` is the zero-extend flag.
- The FSM state encoding is local to the module.
- One natural sub-module: `imm_sel_decoder`, a combinational map from `inst` to `imm_sel` plus the rs1-used and rs2-used flags.

## Test plan
- **Decode:**
  - `inst`=0x000012B7 (LUI) → `imm_sel`=0001.
  - 0x0000006F (JAL) → 0010.
  - 0x00529293 (SLLI) → 0110.
  - 0x00112023 (SW) → 0101.
  - 0x00000063 (BEQ) → 0100.
- **Load-use:** `ex_mem_read`=1, `ex_rd`=5, `inst`=0x00528333 (ADD x6,x5,x5) → `stall_if`=`bubble_ex`=1 for 1 cycle. With `ex_rd`=0, no stall occurs.
- **Divide, `DIV_CYCLES`=4:** issue 0x02C5C533 (DIV) → 0 stall on the issue cycle, then `stall_if`=`div_busy`=1 for 3 cycles, then IDLE. `stall_cycles` reaches 3.
- **Branch priority:** `branch_taken`=1 with a load-use hazard and a DIV in ID → `flush_id`=`bubble_ex`=1, `stall_if`=0, state stays IDLE.
- **Reset mid-DIV_WAIT:** assert `RESET` in the 2nd wait cycle → outputs go to 0 immediately, `stall_cycles`=0, and the state is IDLE after release.
- **Saturation:** force `stall_cycles` to 0xFFFF_FFFE, then apply 3 stall cycles → it holds at 0xFFFF_FFFF.
